// File: rtl/mul_share_arbiter_if.sv
// Bundles the requester and multiplier-side signals of mul_share_arbiter.
// The arbiter takes the slave modport; clients plus multiplier drive the master side.
interface mul_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_multiplicand;
    logic [32*NUM_REQ-1:0] req_multiplier;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [63:0]           resp_product;
    logic                  resp_err;
    logic                  mul_start;
    logic [31:0]           mul_multiplicand;
    logic [31:0]           mul_multiplier;
    logic [63:0]           mul_product;
    logic                  mul_finish;
    logic                  busy;
    logic                  timeout_err;

    modport slave (
        input  req_valid, req_multiplicand, req_multiplier, mul_product, mul_finish,
        output req_ready, resp_valid, resp_product, resp_err, mul_start,
               mul_multiplicand, mul_multiplier, busy, timeout_err
    );

    modport master (
        output req_valid, req_multiplicand, req_multiplier, mul_product, mul_finish,
        input  req_ready, resp_valid, resp_product, resp_err, mul_start,
               mul_multiplicand, mul_multiplier, busy, timeout_err
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one sequential 32x32 multiplier among NUM_REQ requesters,
// one operation in flight at a time, with a watchdog on the multiplier's finish pulse.
module mul_share_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    mul_share_arbiter_if.slave bus
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IdxW-1:0]    r_ptr;
    logic [IdxW-1:0]    r_gnt;
    logic [IdxW-1:0]    w_gnt;
    logic [IdxW-1:0]    w_idx;
    logic               w_found;
    logic [CntW-1:0]    r_cnt;
    logic               w_cnt_last;
    logic [31:0]        r_mcand;
    logic [31:0]        r_mplier;
    logic [63:0]        r_prod;
    logic               r_err;
    logic               r_timeout_err;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_resp_valid;
    logic               w_start;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = IdxW'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_cnt_last = (r_cnt == CntW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = '0;
        w_resp_valid = '0;
        w_start      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_ready[w_gnt] = 1'b1;
                    w_state_nxt    = StIssue;
                end
            end
            StIssue: begin
                w_start     = 1'b1;
                w_state_nxt = StWait;
            end
            StWait: begin
                if (bus.mul_finish || w_cnt_last) begin
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                w_resp_valid[r_gnt] = 1'b1;
                w_state_nxt         = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_ptr         <= '0;
            r_gnt         <= '0;
            r_cnt         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_prod        <= '0;
            r_err         <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && w_found) begin
                r_gnt    <= w_gnt;
                r_mcand  <= bus.req_multiplicand[32*w_gnt +: 32];
                r_mplier <= bus.req_multiplier[32*w_gnt +: 32];
            end
            if (r_state == StIssue) begin
                r_cnt <= '0;
            end
            if (r_state == StWait) begin
                r_cnt <= r_cnt + CntW'(1);
                // A finish on the final allowed cycle still counts as success.
                if (bus.mul_finish) begin
                    r_prod <= bus.mul_product;
                    r_err  <= 1'b0;
                end else if (w_cnt_last) begin
                    r_prod        <= '0;
                    r_err         <= 1'b1;
                    r_timeout_err <= 1'b1;
                end
            end
            if (r_state == StResp) begin
                r_ptr <= (r_gnt == IdxW'(NUM_REQ - 1)) ? '0 : r_gnt + IdxW'(1);
            end
        end
    end

    assign bus.req_ready        = w_ready;
    assign bus.resp_valid       = w_resp_valid;
    assign bus.resp_product     = (r_state == StResp) ? r_prod : '0;
    assign bus.resp_err         = (r_state == StResp) && r_err;
    assign bus.mul_start        = w_start;
    assign bus.mul_multiplicand = r_mcand;
    assign bus.mul_multiplier   = r_mplier;
    assign bus.busy             = (r_state != StIdle);
    assign bus.timeout_err      = r_timeout_err;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one sequential 32x32 multiplier (start/finish pulse handshake, 64-bit product) among NUM_REQ requesters.
- Arbitrates round-robin, issues one operation at a time, returns the product to the winning requester, and watchdogs the multiplier with a timeout.
- Sits between client logic and the multiplier instance, on the same clock and reset as the multiplier.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles in WAIT before the operation is aborted (must be ≥ 2).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i has an operation pending.
- req_multiplicand  input  32*NUM_REQ  requester i operand in bits [32i+31:32i].
- req_multiplier  input  32*NUM_REQ  requester i operand in bits [32i+31:32i].
- req_ready  output  NUM_REQ  one-hot accept; combinational, only in IDLE.
- resp_valid  output  NUM_REQ  one-hot, one-cycle pulse to the owner of the result.
- resp_product  output  64  result; valid only while any resp_valid bit is high.
- resp_err  output  1  high with resp_valid when the op timed out.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_multiplicand  output  32  latched operand, stable from ISSUE through WAIT.
- mul_multiplier  output  32  latched operand, stable from ISSUE through WAIT.
- mul_product  input  64  multiplier result.
- mul_finish  input  1  multiplier completion pulse.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky; set on any timeout, cleared only by rst.

Behaviour:
- Reset (rst high at posedge, wins over everything):
  - State goes to IDLE.
  - Round-robin pointer goes to 0, so requester 0 has top priority.
  - Operand latches, product latch, counter and timeout_err go to 0.
  - All outputs are 0.
- Reset mid-operation aborts the op silently; no resp_valid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant index g = first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 in that same cycle.
  - At the posedge: latch requester g's operands and g; move to ISSUE.
  - No request: stay in IDLE, req_ready=0.
- ISSUE (exactly 1 cycle): mul_start=1; clear counter; move to WAIT.
- WAIT:
  - Counter increments each cycle.
  - mul_finish=1: latch mul_product, clear err flag, move to RESP.
  - Counter == TIMEOUT-1 without finish: product latch=0, err flag=1, timeout_err<=1, move to RESP.
  - Finish in the same cycle as the timeout: finish wins, no error.
- RESP (1 cycle):
  - resp_valid[g]=1; resp_product and resp_err come from the latches.
  - ptr <= (g+1) mod NUM_REQ; move to IDLE.
- mul_finish in IDLE, ISSUE or RESP is ignored.
- Latency: handshake at cycle T, mul_start at T+1, finish sampled at cycle F, resp_valid at F+1, next accept possible at F+2.
- Requester rules:
  - A requester must hold req_valid and its operands until req_ready.
  - Operand changes after acceptance have no effect.
  - req_valid may stay high for the next op; it is eligible again at the next IDLE.
- Fairness: with all requesters valid, grants rotate 0,1,…,NUM_REQ-1,0. Pointer wrap from NUM_REQ-1 goes to 0.
- Products pass through unmodified (unsigned, full 64 bits).
- mul_multiplicand and mul_multiplier hold their last latched values in IDLE.

Test Plan:
- Single op, NUM_REQ=2: requester 0 sends 0xFFFFFFFF × 0x2, model finishes 32 cycles after start → resp_valid=2'b01, resp_product=0x1_FFFFFFFE, resp_err=0; timing T, T+1, F+1 as specified.
- Contention: both valid from reset, ops 3×5 (req0) and 7×9 (req1), held continuously for 4 ops → grant order 0,1,0,1; products 15, 63; mul_start pulses never overlap an in-flight op.
- Timeout: model never asserts finish → resp_valid at start+TIMEOUT+1 with resp_product=0 and resp_err=1; timeout_err stays 1 until rst, and the next normal op completes with resp_err=0.
- Finish on last allowed cycle: mul_finish at counter==TIMEOUT-1 with product 0x1234 → resp_err=0, timeout_err=0, resp_product=0x1234.
- Reset mid-WAIT: rst at cycle 10 of an op → no resp_valid; busy=0 and ptr=0 next cycle; a stray mul_finish after reset is ignored.
- Robustness: spurious mul_finish in IDLE, and operand change after acceptance → no resp_valid, and the latched operands are unchanged.
